fp_round_pack: RTL
==================

Name: fp_round_pack

Overview:
- Pipelined rounding/packing stage directly downstream of the FMUL multiplier core.
- Takes FMUL's raw result: sign, exp[7:0], frac[23:0] (frac[23:1] = fraction, frac[0] = guard bit), error, overflow.
- Applies IEEE-754 round-to-nearest-even and special-value encoding, then emits a packed 32-bit single-precision word with flags.
- Uses a valid/ready handshake; keeps saturating event counters for test and debug.

Parameters:
- CNT_W, 16, width of the NaN and overflow event counters (saturating).
- TAG_W, 2, width of the opaque tag carried alongside each result (operation select code).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat (combinational).
- in_sign  in  1  FMUL sign.
- in_exp  in  8  FMUL biased exponent.
- in_frac  in  24  FMUL fraction; [23:1] fraction, [0] guard.
- in_sticky  in  1  OR of bits below guard; tie to 0 when the source has none.
- in_error  in  1  FMUL invalid-operation (NaN result).
- in_overflow  in  1  FMUL exponent overflow.
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  32  packed IEEE-754 word.
- out_tag  out  TAG_W  tag of out_result.
- out_nan  out  1  result is quiet NaN.
- out_inf  out  1  result is ±Inf.
- out_inexact  out  1  guard|sticky was set on a finite, non-special result.
- out_round_ovf  out  1  rounding carry pushed exp to 255.
- cnt_clr  in  1  synchronous clear of both counters.
- nan_cnt  out  CNT_W  NaN results delivered.
- ovf_cnt  out  CNT_W  Inf results delivered (in_overflow or round_ovf).

Behaviour:
- Reset (rst_n=0 at an edge): both stage valids, out_result, out_tag, all flags and both counters go to 0. Any in-flight beats are dropped. in_ready=1 in the first cycle after reset.
- Two-stage pipeline: S1 = round, S2 = pack/classify. Latency is exactly 2 cycles from acceptance to out_valid when unstalled. Throughput is 1 beat/cycle.
- Handshake:
  - A beat transfers when valid&ready.
  - S2 advances when !s2_v | out_ready.
  - in_ready = !s1_v | s2_advance.
  - Output fields are stable while out_valid & !out_ready.
  - No loss, duplication or reordering.
- S1 rounding on a normal beat, with l = in_frac[1], g = in_frac[0], s = in_sticky:
  - up = g & (s | l).
  - {c, f23} = in_frac[23:1] + up.
  - If c=1: f23 = 0 and e = in_exp + 1, computed 9 bits wide.
- S2 priority and packing:
  1. in_error → 32'h7FC00000, out_nan=1.
  2. in_overflow → {sign, 8'hFF, 23'h0}, out_inf=1.
  3. in_exp==8'hFF (Inf passthrough) → {sign, 8'hFF, in_frac[23:1]}, no rounding.
  4. Rounded e==255 → {sign, 8'hFF, 0}, out_inf=1, out_round_ovf=1.
  5. Otherwise → {sign, e[7:0], f23}, out_inexact = g|s.
  - In cases 1–4, out_inexact=0 except case 4, where it is 1.
- Zero/denormal: in_exp==0 with in_frac[23:1]==0 packs as ±0 with no rounding. Denormal inputs are packed unrounded (FMUL flushes them).
- Counters:
  - Increment once per output transfer (out_valid&out_ready) with out_nan (nan_cnt) or out_inf (ovf_cnt).
  - Saturate at all-ones.
  - cnt_clr has priority over a same-cycle increment.
- Simultaneous in/out transfers in a full pipe are legal and sustain 1/cycle.

Decomposition:
- Shared package fp_pkg:
  - Constants: FP_QNAN=32'h7FC00000, FP_EXP_MAX=8'hFF, FP_FRAC_W=23, FP_EXP_W=8.
  - Typedef fp_raw_t {sign, exp, frac[23:0], sticky, error, overflow}.
- Sub-module fp_round_rne: combinational RNE increment. Inputs frac[23:0] and sticky; outputs f23, carry, inexact. Instantiated in S1.

Test Plan:
- sign0, exp 0x82, frac 24'h020100, g=s=0 → 0x41010080, all flags 0, out_valid exactly 2 cycles after acceptance.
- exp 0x7F, frac 24'h000003, s=0 → 0x3F800002, inexact=1. frac 24'h000001 → 0x3F800000, inexact=1 (ties-to-even down).
- exp 0x7F, frac 24'hFFFFFF → 0x40000000. exp 0xFE, frac 24'hFFFFFF → 0x7F800000, out_inf=1, out_round_ovf=1, ovf_cnt=1.
- error=1 (any fields) → 0x7FC00000, out_nan=1, nan_cnt+1. overflow=1, sign1 → 0xFF800000, out_inf=1.
- out_ready=0 for 4 cycles while driving 3 beats → in_ready drops after 2 accepts. Release → 3 results in order with matching tags, none lost or duplicated.
- rst_n=0 for one cycle with 2 beats in flight → out_valid=0 and counters 0 next cycle, stale beats never emerge. Separately, cnt_clr with a same-cycle NaN transfer → nan_cnt=0.

Source files
------------

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision constants and raw multiplier result type
package fp_pkg;

  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam int          FP_FRAC_W  = 23;
  localparam int          FP_EXP_W   = 8;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W:0]   frac;
    logic                 sticky;
    logic                 error;
    logic                 overflow;
  } fp_raw_t;

endpackage

// File: rtl/fp_round_pack_if.sv
// rtl/fp_round_pack_if.sv - input/output handshake bundle of the rounding/packing stage
interface fp_round_pack_if
  import fp_pkg::*;
#(
  parameter int TAG_W = 2
);

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sign;
  logic [FP_EXP_W-1:0]  in_exp;
  logic [FP_FRAC_W:0]   in_frac;
  logic                 in_sticky;
  logic                 in_error;
  logic                 in_overflow;
  logic [TAG_W-1:0]     in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_result;
  logic [TAG_W-1:0]     out_tag;
  logic                 out_nan;
  logic                 out_inf;
  logic                 out_inexact;
  logic                 out_round_ovf;

  modport master (
    output in_valid, in_sign, in_exp, in_frac, in_sticky, in_error, in_overflow, in_tag,
    input  in_ready,
    input  out_valid, out_result, out_tag, out_nan, out_inf, out_inexact, out_round_ovf,
    output out_ready
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_frac, in_sticky, in_error, in_overflow, in_tag,
    output in_ready,
    output out_valid, out_result, out_tag, out_nan, out_inf, out_inexact, out_round_ovf,
    input  out_ready
  );

endinterface

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - combinational round-to-nearest-even increment of a guarded fraction
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [FP_FRAC_W:0]   frac,
  input  logic                 sticky,
  output logic [FP_FRAC_W-1:0] f23,
  output logic                 carry,
  output logic                 inexact
);

  logic up;

  // Round up above the halfway point, or exactly at it when the kept lsb is odd.
  assign up      = frac[0] & (sticky | frac[1]);
  assign {carry, f23} = {1'b0, frac[FP_FRAC_W:1]} + {{FP_FRAC_W{1'b0}}, up};
  assign inexact = frac[0] | sticky;

endmodule

// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - two-stage round (S1) and pack/classify (S2) pipeline with event counters
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int TAG_W = 2
)(
  input  logic             clk,
  input  logic             rst_n,
  fp_round_pack_if.slave   bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] nan_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  fp_raw_t                raw;
  logic                   s1_v, s2_v, s2_adv, in_fire, out_fire, round_en;
  logic                   s1_sign, s1_error, s1_overflow, s1_inf_pass, s1_inexact;
  logic [FP_EXP_W:0]      s1_e, e_next;
  logic [FP_FRAC_W-1:0]   s1_f23, f_next, rn_f23;
  logic [TAG_W-1:0]       s1_tag;
  logic                   rn_carry, rn_inexact, inexact_next;
  logic [31:0]            pk_res;
  logic                   pk_nan, pk_inf, pk_inx, pk_rovf;

  assign raw = '{sign: bus.in_sign, exp: bus.in_exp, frac: bus.in_frac,
                 sticky: bus.in_sticky, error: bus.in_error, overflow: bus.in_overflow};

  assign s2_adv       = !s2_v | bus.out_ready;
  assign bus.in_ready = !s1_v | s2_adv;
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign out_fire     = s2_v & bus.out_ready;
  assign bus.out_valid = s2_v;

  fp_round_rne u_rne (
    .frac    (raw.frac),
    .sticky  (raw.sticky),
    .f23     (rn_f23),
    .carry   (rn_carry),
    .inexact (rn_inexact)
  );

  // Zero/denormal and Inf/NaN-exponent inputs bypass rounding entirely.
  assign round_en = (raw.exp != '0) && (raw.exp != FP_EXP_MAX);

  always_comb begin
    e_next       = {1'b0, raw.exp};
    f_next       = raw.frac[FP_FRAC_W:1];
    inexact_next = 1'b0;
    if (round_en) begin
      e_next       = {1'b0, raw.exp} + {{FP_EXP_W{1'b0}}, rn_carry};
      f_next       = rn_f23;
      inexact_next = rn_inexact;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
    end else begin
      if (bus.in_ready) s1_v <= bus.in_valid;
      if (in_fire) begin
        s1_sign     <= raw.sign;
        s1_error    <= raw.error;
        s1_overflow <= raw.overflow;
        s1_inf_pass <= (raw.exp == FP_EXP_MAX);
        s1_inexact  <= inexact_next;
        s1_e        <= e_next;
        s1_f23      <= f_next;
        s1_tag      <= bus.in_tag;
      end
    end
  end

  always_comb begin
    pk_res  = {s1_sign, s1_e[FP_EXP_W-1:0], s1_f23};
    pk_nan  = 1'b0;
    pk_inf  = 1'b0;
    pk_inx  = s1_inexact;
    pk_rovf = 1'b0;
    if (s1_error) begin
      pk_res = FP_QNAN;
      pk_nan = 1'b1;
      pk_inx = 1'b0;
    end else if (s1_overflow) begin
      pk_res = {s1_sign, FP_EXP_MAX, {FP_FRAC_W{1'b0}}};
      pk_inf = 1'b1;
      pk_inx = 1'b0;
    end else if (s1_inf_pass) begin
      pk_res = {s1_sign, FP_EXP_MAX, s1_f23};
      pk_inx = 1'b0;
    end else if (s1_e == {1'b0, FP_EXP_MAX}) begin
      pk_res  = {s1_sign, FP_EXP_MAX, {FP_FRAC_W{1'b0}}};
      pk_inf  = 1'b1;
      pk_inx  = 1'b1;
      pk_rovf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v              <= 1'b0;
      bus.out_result    <= '0;
      bus.out_tag       <= '0;
      bus.out_nan       <= 1'b0;
      bus.out_inf       <= 1'b0;
      bus.out_inexact   <= 1'b0;
      bus.out_round_ovf <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        bus.out_result    <= pk_res;
        bus.out_tag       <= s1_tag;
        bus.out_nan       <= pk_nan;
        bus.out_inf       <= pk_inf;
        bus.out_inexact   <= pk_inx;
        bus.out_round_ovf <= pk_rovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      nan_cnt <= '0;
      ovf_cnt <= '0;
    end else if (out_fire) begin
      if (bus.out_nan && nan_cnt != '1) nan_cnt <= nan_cnt + 1'b1;
      if (bus.out_inf && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule
